apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_slave_regfile.sv | 49 ++++
 rtl/apb_slave_mem.sv | 116 +++++++++++
 tb/tb_apb_slave_mem.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave memory: FSM state encoding and response codes.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1
  } apb_state_e;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W storage: byte-strobed synchronous write, combinational read, synchronous clear.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(addr) < DEPTH)) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_d[addr][i*8 +: 8] = wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(addr) < DEPTH) begin
      rdata = mem_q[addr];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small byte-strobed memory, fixed wait states and an external wait request.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic                s_wait,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - LSB;
  localparam int unsigned RF_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              err;
  logic              wr_en;
  logic [DATA_W-1:0] rf_rdata;

  assign word_idx = paddr[ADDR_W-1:LSB];
  assign in_range = ({1'b0, word_idx} < DEPTH_L);
  assign err      = !in_range || (!pwrite && (pstrb != '0));

  generate
    if (LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^paddr[LSB-1:0];
    end
  endgenerate

  // Gated by preset so nothing completes (and nothing is written) on a reset edge.
  always_comb begin
    pready = !preset && (state_q == ACCESS) && psel && penable
             && (cnt_q == '0) && !s_wait;
  end

  always_comb begin
    pslverr = (pready && err) ? SLVERR : OKAY;
    wr_en   = pready && pwrite && !err;
    prdata  = (pready && !pwrite && !err) ? rf_rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (pready) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RF_AW)
  ) u_regfile (
    .clk   (pclk),
    .clr   (preset),
    .we    (wr_en),
    .addr  (word_idx[RF_AW-1:0]),
    .wstrb (pstrb),
    .wdata (pwdata),
    .rdata (rf_rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: two instances (0 and 3 wait states) against an array-based memory model.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  paddr;
  logic        psel0, psel3, penable, pwrite, s_wait;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [2][16];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .s_wait(s_wait),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .s_wait(s_wait),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  function automatic logic exp_err(input logic [7:0] a, input logic wr, input logic [3:0] sb);
    return (int'(a) / 4 >= 16) || (!wr && sb != 4'h0);
  endfunction

  task automatic sample(input int which, output logic r, output logic e, output logic [31:0] d);
    if (which == 3) begin r = pready3; e = pslverr3; d = prdata3; end
    else            begin r = pready0; e = pslverr0; d = prdata0; end
  endtask

  // One complete transfer; s_wait is high during ACCESS cycles [ws_start, ws_start+ws_len).
  task automatic xfer(input int which, input logic [7:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] sb, input int ws_start, input int ws_len, input string tag);
    int w, m, idx;
    logic r, e, exp_r, exp_e;
    logic [31:0] d, exp_d;
    bit done;
    w = (which == 3) ? 3 : 0;
    m = (which == 3) ? 1 : 0;
    idx = int'(a) / 4;
    done = 0;
    @(negedge pclk);
    psel0 = (which == 0); psel3 = (which == 3); penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = sb; s_wait = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    for (int c = 1; c <= 40 && !done; c++) begin
      s_wait = (c >= ws_start && c < ws_start + ws_len);
      #1;
      sample(which, r, e, d);
      exp_r = (c - 1 >= w) && !s_wait;
      checks++;
      if (r !== exp_r) begin
        errors++;
        $display("FAIL %s pready access cycle %0d: got %b expected %b", tag, c, r, exp_r);
      end
      if (exp_r) begin
        exp_e = exp_err(a, wr, sb);
        exp_d = (!wr && !exp_e) ? mdl[m][idx] : 32'h0;
        checks++;
        if (e !== exp_e) begin
          errors++;
          $display("FAIL %s pslverr: got %b expected %b", tag, e, exp_e);
        end
        checks++;
        if (d !== exp_d) begin
          errors++;
          $display("FAIL %s prdata: got %h expected %h", tag, d, exp_d);
        end
        if (wr && !exp_e)
          for (int i = 0; i < 4; i++)
            if (sb[i]) mdl[m][idx][i*8 +: 8] = wd[i*8 +: 8];
        done = 1;
      end else begin
        checks++;
        if ({e, d} !== 33'h0) begin
          errors++;
          $display("FAIL %s idle outputs cycle %0d: got err=%b data=%h expected 0/0", tag, c, e, d);
        end
        @(negedge pclk);
      end
    end
    s_wait = 1'b0;
  endtask

  task automatic idle(input string tag);
    @(negedge pclk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; s_wait = 1'b0;
    #1;
    checks++;
    if ({pready0, pready3, pslverr0, pslverr3} !== 4'h0 || prdata0 !== 32'h0 || prdata3 !== 32'h0) begin
      errors++;
      $display("FAIL %s idle: got rdy=%b%b err=%b%b expected all 0", tag, pready0, pready3,
               pslverr0, pslverr3);
    end
  endtask

  task automatic check_all_words(input int which, input string tag);
    for (int k = 0; k < 16; k++) xfer(which, 8'(k * 4), 1'b0, 32'h0, 4'h0, 0, 0, tag);
    idle(tag);
  endtask

  task automatic test_reset();
    preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; s_wait = 1'b0;
    for (int m = 0; m < 2; m++) for (int k = 0; k < 16; k++) mdl[m][k] = 32'h0;
    repeat (2) @(negedge pclk);
    #1;
    checks++;
    if ({pready0, pready3, pslverr0, pslverr3} !== 4'h0 || prdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b err=%b%b expected 0", pready0, pready3, pslverr0, pslverr3);
    end
    @(negedge pclk);
    preset = 1'b0;
    idle("reset_release");
  endtask

  task automatic test_basic_rw();
    xfer(0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0, 0, "basic_wr");
    xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 0, 0, "basic_rd");
    idle("basic_end");
  endtask

  task automatic test_strobes();
    xfer(0, 8'h08, 1'b1, 32'h11223344, 4'hF, 0, 0, "strb_full");
    xfer(0, 8'h08, 1'b1, 32'hAABBCCDD, 4'h5, 0, 0, "strb_part");
    xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, 0, 0, "strb_rd");
    checks++;
    if (mdl[0][2] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strb_model: got %h expected 11bb33dd", mdl[0][2]);
    end
    idle("strb_end");
  endtask

  task automatic test_wait_states();
    xfer(3, 8'h10, 1'b1, 32'hCAFEF00D, 4'hF, 0, 0, "wait_wr");
    xfer(3, 8'h10, 1'b0, 32'h0, 4'h0, 4, 2, "wait_swait");
    idle("wait_one_cycle");
    xfer(3, 8'h10, 1'b0, 32'h0, 4'h0, 1, 7, "wait_long_stall");
    idle("wait_end");
  endtask

  task automatic test_errors();
    xfer(0, 8'h40, 1'b1, 32'h55AA55AA, 4'hF, 0, 0, "oor_wr");
    xfer(0, 8'h40, 1'b0, 32'h0, 4'h0, 0, 0, "oor_rd");
    xfer(0, 8'h04, 1'b0, 32'h0, 4'h3, 0, 0, "rd_strb_err");
    xfer(3, 8'hFC, 1'b1, 32'h12345678, 4'hF, 2, 1, "oor_wr_w3");
    check_all_words(0, "oor_words");
  endtask

  task automatic test_no_setup();
    @(negedge pclk);
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pready0 !== 1'b0) begin
        errors++;
        $display("FAIL no_setup pready cycle %0d: got %b expected 0", c, pready0);
      end
      @(negedge pclk);
    end
    idle("no_setup_idle");
    xfer(0, 8'h0C, 1'b0, 32'h0, 4'h0, 0, 0, "no_setup_rd");
    idle("no_setup_end");
  endtask

  task automatic test_abort();
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hFEEDFACE; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    checks++;
    if (pready3 !== 1'b0) begin
      errors++; $display("FAIL abort_c1 pready: got %b expected 0", pready3);
    end
    @(negedge pclk);
    psel3 = 1'b0; penable = 1'b0;
    #1;
    checks++;
    if (pready3 !== 1'b0) begin
      errors++; $display("FAIL abort_c2 pready: got %b expected 0", pready3);
    end
    xfer(3, 8'h20, 1'b0, 32'h0, 4'h0, 0, 0, "abort_rd");
    idle("abort_end");
  endtask

  task automatic test_reset_mid();
    xfer(3, 8'h24, 1'b1, 32'h01020304, 4'hF, 0, 0, "rmid_pre3");
    xfer(0, 8'h24, 1'b1, 32'h05060708, 4'hF, 0, 0, "rmid_pre0");
    @(negedge pclk);
    psel0 = 1'b1; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 8'h28;
    pwdata = 32'h99999999; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b1;
    #1;
    checks++;
    if ({pready0, pslverr0} !== 2'b00 || prdata0 !== 32'h0) begin
      errors++;
      $display("FAIL rmid_in_reset: got rdy=%b err=%b data=%h expected 0", pready0, pslverr0, prdata0);
    end
    for (int m = 0; m < 2; m++) for (int k = 0; k < 16; k++) mdl[m][k] = 32'h0;
    @(negedge pclk);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    idle("rmid_after");
    check_all_words(0, "rmid_words0");
    check_all_words(3, "rmid_words3");
  endtask

  task automatic test_back_to_back();
    int which, ws_start, ws_len;
    logic wr;
    logic [7:0] a;
    logic [3:0] sb;
    for (int n = 0; n < 80; n++) begin
      which = ($urandom_range(0, 1) == 1) ? 3 : 0;
      a = 8'($urandom_range(0, 8'h4F));
      wr = 1'($urandom_range(0, 1));
      sb = 4'($urandom);
      if (!wr && $urandom_range(0, 4) != 0) sb = 4'h0;
      ws_start = $urandom_range(1, 6);
      ws_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      xfer(which, a, wr, $urandom, sb, ws_start, ws_len, "b2b");
      if ($urandom_range(0, 5) == 0) idle("b2b_gap");
    end
    idle("b2b_end");
    check_all_words(0, "b2b_words0");
    check_all_words(3, "b2b_words3");
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_strobes();
    test_wait_states();
    test_errors();
    test_no_setup();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
